dram_ctrl_initiator: RTL and testbench

- Memory-side initiator that drives the off-chip DRAM pin interface (CSn/WEn/RASn/CASn/A/D in, Q/VALID back).
- Converts single-word read/write requests from the bus slave wrapper into PRECHARGE/ACTIVATE/READ/WRITE command sequences.
- Uses an open-row policy.
- Sits between the system bus DRAM slave port and the top-level DRAM pins.

---
 rtl/dram_ctrl_pkg.sv | 38 +++
 rtl/dram_wait_timer.sv | 24 ++
 rtl/dram_ctrl_initiator.sv | 228 ++++++++++++++++++++++
 tb/tb_dram_ctrl_initiator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and command encodings for the DRAM pin-level initiator.
package dram_ctrl_pkg;

  localparam int unsigned ROW_W = 11;
  localparam int unsigned COL_W = 10;

  typedef enum logic [3:0] {
    StIdle,
    StPre,
    StPreWait,
    StAct,
    StActWait,
    StRd,
    StRdWait,
    StWr,
    StWrWait,
    StResp
  } state_t;

  typedef struct packed {
    logic       csn;
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } cmd_t;

  localparam cmd_t CMD_PRE   = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
  localparam cmd_t CMD_ACT   = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
  localparam cmd_t CMD_RD    = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};
  localparam cmd_t CMD_NOP   = '{csn: 1'b0, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam cmd_t CMD_DESEL = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};

  // WRITE carries the byte enables on the active-low WEn lines.
  function automatic cmd_t cmd_wr(input logic [3:0] wstrb);
    return '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: ~wstrb};
  endfunction

endpackage

// File: rtl/dram_wait_timer.sv
// Loadable 8-bit down-counter; done is high whenever the count has reached zero.
module dram_wait_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/dram_ctrl_initiator.sv
// Turns single-word bus requests into PRE/ACT/RD/WR pin sequences with an open-row policy.
module dram_ctrl_initiator
  import dram_ctrl_pkg::*;
#(
  parameter int unsigned T_RP       = 5,
  parameter int unsigned T_RCD      = 5,
  parameter int unsigned T_WR       = 5,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        DRAM_CSn,
  output logic [3:0]  DRAM_WEn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  localparam logic [7:0] LD_RP  = 8'(T_RP - 1);
  localparam logic [7:0] LD_RCD = 8'(T_RCD - 1);
  localparam logic [7:0] LD_WR  = 8'(T_WR - 1);
  localparam logic [7:0] LD_TO  = 8'(RD_TIMEOUT - 1);

  state_t           state_q;
  cmd_t             cmd_q;
  logic             row_open_q, force_pre_q;
  logic [ROW_W-1:0] open_row_q, row_q;
  logic [COL_W-1:0] col_q;
  logic             write_q;
  logic [3:0]       wstrb_q;
  logic [31:0]      wdata_q;

  logic [ROW_W-1:0] req_row, acc_row;
  logic [COL_W-1:0] req_col, acc_col;
  logic             acc_write;
  logic [3:0]       acc_wstrb;
  logic [31:0]      acc_wdata;
  logic             tmr_load, tmr_done;
  logic [7:0]       tmr_val;
  logic             unused_addr_bits;

  assign req_row          = req_addr[22:12];
  assign req_col          = req_addr[11:2];
  assign unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

  // Commands issued straight from IDLE use the live request; later ones use the latched copy.
  always_comb begin
    acc_row   = row_q;
    acc_col   = col_q;
    acc_write = write_q;
    acc_wstrb = wstrb_q;
    acc_wdata = wdata_q;
    if (state_q == StIdle) begin
      acc_row   = req_row;
      acc_col   = req_col;
      acc_write = req_write;
      acc_wstrb = req_wstrb;
      acc_wdata = req_wdata;
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StPre:   begin tmr_load = 1'b1; tmr_val = LD_RP;  end
      StAct:   begin tmr_load = 1'b1; tmr_val = LD_RCD; end
      StRd:    begin tmr_load = 1'b1; tmr_val = LD_TO;  end
      StWr:    begin tmr_load = 1'b1; tmr_val = LD_WR;  end
      default: ;
    endcase
  end

  dram_wait_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= CMD_DESEL;
      DRAM_A      <= '0;
      DRAM_D      <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      row_open_q  <= 1'b0;
      force_pre_q <= 1'b0;
      open_row_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      write_q     <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            row_q     <= req_row;
            col_q     <= req_col;
            write_q   <= req_write;
            wstrb_q   <= req_wstrb;
            wdata_q   <= req_wdata;
            if (force_pre_q || (row_open_q && req_row != open_row_q)) begin
              cmd_q       <= CMD_PRE;
              row_open_q  <= 1'b0;
              force_pre_q <= 1'b0;
              state_q     <= StPre;
            end else if (!row_open_q) begin
              cmd_q      <= CMD_ACT;
              DRAM_A     <= acc_row;
              open_row_q <= acc_row;
              row_open_q <= 1'b1;
              state_q    <= StAct;
            end else if (acc_write) begin
              cmd_q   <= cmd_wr(acc_wstrb);
              DRAM_A  <= {1'b0, acc_col};
              DRAM_D  <= acc_wdata;
              state_q <= StWr;
            end else begin
              cmd_q   <= CMD_RD;
              DRAM_A  <= {1'b0, acc_col};
              state_q <= StRd;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        StPre: begin
          cmd_q   <= CMD_NOP;
          state_q <= StPreWait;
        end
        StPreWait: begin
          if (tmr_done) begin
            cmd_q      <= CMD_ACT;
            DRAM_A     <= acc_row;
            open_row_q <= acc_row;
            row_open_q <= 1'b1;
            state_q    <= StAct;
          end
        end
        StAct: begin
          cmd_q   <= CMD_NOP;
          state_q <= StActWait;
        end
        StActWait: begin
          if (tmr_done) begin
            DRAM_A <= {1'b0, acc_col};
            if (acc_write) begin
              cmd_q   <= cmd_wr(acc_wstrb);
              DRAM_D  <= acc_wdata;
              state_q <= StWr;
            end else begin
              cmd_q   <= CMD_RD;
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          cmd_q   <= CMD_NOP;
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (DRAM_valid) begin
            rsp_rdata <= DRAM_Q;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else if (tmr_done) begin
            // The device state is unknown after a lost read, so force a precharge next time.
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            row_open_q  <= 1'b0;
            force_pre_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StWr: begin
          cmd_q   <= CMD_NOP;
          state_q <= StWrWait;
        end
        StWrWait: begin
          if (tmr_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DRAM_CSn  = cmd_q.csn;
  assign DRAM_RASn = cmd_q.rasn;
  assign DRAM_CASn = cmd_q.casn;
  assign DRAM_WEn  = cmd_q.wen;

endmodule

// File: tb/tb_dram_ctrl_initiator.sv
// Directed bench for dram_ctrl_initiator with a behavioural DRAM and a pin-command log.
module tb_dram_ctrl_initiator;

  localparam int T_RP = 5, T_RCD = 5, T_WR = 5, RD_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q = '0;
  logic        DRAM_valid = 1'b0;

  dram_ctrl_initiator #(
    .T_RP(T_RP), .T_RCD(T_RCD), .T_WR(T_WR), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DRAM_CSn(DRAM_CSn), .DRAM_WEn(DRAM_WEn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_A(DRAM_A), .DRAM_D(DRAM_D), .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DESEL, K_NOP, K_PRE, K_ACT, K_RD, K_WR, K_BAD} kind_e;

  function automatic kind_e decode(input logic csn, input logic rasn, input logic casn,
                                   input logic [3:0] wen);
    if (csn) return K_DESEL;
    if (!rasn && casn && wen == 4'h0) return K_PRE;
    if (!rasn && casn && wen == 4'hF) return K_ACT;
    if (rasn && !casn && wen == 4'hF) return K_RD;
    if (rasn && !casn) return K_WR;
    if (rasn && casn && wen == 4'hF) return K_NOP;
    return K_BAD;
  endfunction

  // Log of what the pins showed in each cycle.
  int          cyc = 0;
  kind_e       kind_at [0:4095];
  logic [10:0] a_at    [0:4095];
  logic [3:0]  wen_at  [0:4095];
  logic [31:0] d_at    [0:4095];

  always @(posedge clk) begin
    if (cyc < 4096) begin
      kind_at[cyc] <= decode(DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn);
      a_at[cyc]    <= DRAM_A;
      wen_at[cyc]  <= DRAM_WEn;
      d_at[cyc]    <= DRAM_D;
    end
    cyc <= cyc + 1;
  end

  // Behavioural DRAM: read data returns three cycles after the RD command.
  logic [31:0] mem [bit [20:0]];
  logic [10:0] act_row = '0;
  logic [20:0] rd_word = '0;
  int          pend = 0;
  bit          valid_en = 1'b1;

  always @(posedge clk) begin
    logic [31:0] tmp;
    logic [20:0] w;
    kind_e       k;
    k = decode(DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn);
    DRAM_valid <= 1'b0;
    DRAM_Q     <= 32'hFFFF_0000;
    if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1 && valid_en) begin
        DRAM_valid <= 1'b1;
        DRAM_Q     <= mem[rd_word];
      end
    end
    if (k == K_ACT) act_row <= DRAM_A;
    if (k == K_RD) begin
      pend    <= 2;
      rd_word <= {act_row, DRAM_A[9:0]};
    end
    if (k == K_WR) begin
      w   = {act_row, DRAM_A[9:0]};
      tmp = mem.exists(w) ? mem[w] : 32'h0;
      for (int b = 0; b < 4; b++) if (!DRAM_WEn[b]) tmp[8*b +: 8] = DRAM_D[8*b +: 8];
      mem[w] = tmp;
    end
  end

  int total = 0, passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int first_kind(input kind_e k, input int from, input int to);
    for (int i = from; i <= to; i++) if (kind_at[i] == k) return i;
    return -1;
  endfunction

  function automatic int count_kind(input kind_e k, input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (kind_at[i] == k) n++;
    return n;
  endfunction

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, output int hs);
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = data;
    req_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        hs = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hs < 0) check("handshake_timeout", 64'd0, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (rc < 0) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_pins(input string pfx);
    check({pfx, "_csn"}, DRAM_CSn, 1'b1);
    check({pfx, "_rasn"}, DRAM_RASn, 1'b1);
    check({pfx, "_casn"}, DRAM_CASn, 1'b1);
    check({pfx, "_wen"}, DRAM_WEn, 4'hF);
    check({pfx, "_a"}, DRAM_A, 11'h0);
    check({pfx, "_d"}, DRAM_D, 32'h0);
    check({pfx, "_req_ready"}, req_ready, 1'b0);
    check({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
    check({pfx, "_rsp_err"}, rsp_err, 1'b0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hs, rc, r, a;
    bit seen;
    mem[21'h40001] = 32'hDEAD_BEEF;
    mem[21'h40002] = 32'hCAFE_F00D;
    mem[21'h80000] = 32'hAABB_CCDD;
    mem[21'h80001] = 32'h5566_7788;
    mem[21'hC0000] = 32'h0BAD_F00D;

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    rst = 1'b0;

    // Cold read: ACT, T_RCD NOPs, RD, no PRE.
    do_req(1'b0, 32'h0010_0004, 4'h0, 32'h0, hs);
    wait_rsp(rc);
    a = first_kind(K_ACT, hs, rc);
    r = first_kind(K_RD, hs, rc);
    check("t1_act_cycle", a, hs + 1);
    check("t1_act_addr", a_at[hs + 1], 11'h100);
    check("t1_rd_cycle", r, hs + T_RCD + 2);
    check("t1_rd_addr", a_at[hs + T_RCD + 2], 11'h001);
    check("t1_nop_gap", count_kind(K_NOP, hs + 2, hs + T_RCD + 1), T_RCD);
    check("t1_no_pre", count_kind(K_PRE, hs, rc), 0);
    check("t1_rsp_cycle", rc, hs + T_RCD + 6);
    check("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("t1_err", rsp_err, 1'b0);
    release_rsp();

    // Row hit: RD on the cycle after the handshake.
    do_req(1'b0, 32'h0010_0008, 4'h0, 32'h0, hs);
    wait_rsp(rc);
    check("t2_rd_cycle", first_kind(K_RD, hs, rc), hs + 1);
    check("t2_rd_addr", a_at[hs + 1], 11'h002);
    check("t2_no_act_pre", count_kind(K_ACT, hs, rc) + count_kind(K_PRE, hs, rc), 0);
    check("t2_rdata", rsp_rdata, 32'hCAFE_F00D);
    release_rsp();

    // Row miss write: PRE, ACT 0x200, WR with byte enables.
    do_req(1'b1, 32'h0020_0000, 4'b0101, 32'h1122_3344, hs);
    wait_rsp(rc);
    check("t3_pre_cycle", first_kind(K_PRE, hs, rc), hs + 1);
    check("t3_act_cycle", first_kind(K_ACT, hs, rc), hs + T_RP + 2);
    check("t3_act_addr", a_at[hs + T_RP + 2], 11'h200);
    r = hs + T_RP + T_RCD + 3;
    check("t3_wr_cycle", first_kind(K_WR, hs, rc), r);
    check("t3_wr_wen", wen_at[r], 4'b1010);
    check("t3_wr_d", d_at[r], 32'h1122_3344);
    check("t3_wr_addr", a_at[r], 11'h000);
    check("t3_no_rd", count_kind(K_RD, hs, rc), 0);
    check("t3_rsp_cycle", rc, r + T_WR + 1);
    check("t3_rdata", rsp_rdata, 32'h0);
    check("t3_err", rsp_err, 1'b0);
    check("t3_mem", mem[21'h80000], 32'hAA22_CC44);
    release_rsp();

    // Read timeout on an open-row hit.
    valid_en = 1'b0;
    do_req(1'b0, 32'h0020_0004, 4'h0, 32'h0, hs);
    wait_rsp(rc);
    check("t4_rd_cycle", first_kind(K_RD, hs, rc), hs + 1);
    check("t4_rsp_cycle", rc, hs + RD_TIMEOUT + 2);
    check("t4_err", rsp_err, 1'b1);
    check("t4_rdata", rsp_rdata, 32'h0);
    valid_en = 1'b1;
    release_rsp();

    // Same row after timeout must precharge first; response held for 10 cycles.
    do_req(1'b0, 32'h0020_0004, 4'h0, 32'h0, hs);
    wait_rsp(rc);
    check("t5_pre_cycle", first_kind(K_PRE, hs, rc), hs + 1);
    check("t5_act_cycle", first_kind(K_ACT, hs, rc), hs + T_RP + 2);
    check("t5_act_addr", a_at[hs + T_RP + 2], 11'h200);
    check("t5_rd_cycle", first_kind(K_RD, hs, rc), hs + T_RP + T_RCD + 3);
    check("t5_rdata", rsp_rdata, 32'h5566_7788);
    check("t5_err", rsp_err, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", rsp_valid, 1'b1);
      check("t5_hold_rdata", rsp_rdata, 32'h5566_7788);
      check("t5_hold_ready", req_ready, 1'b0);
    end
    release_rsp();
    check("t5_after_valid", rsp_valid, 1'b0);
    check("t5_after_ready", req_ready, 1'b1);

    // Reset in ACT_WAIT abandons the transaction.
    do_req(1'b0, 32'h0030_0000, 4'h0, 32'h0, hs);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_act_seen", seen, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_pins("t6_reset");
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("t6_no_rsp", seen, 1'b0);
    do_req(1'b0, 32'h0030_0000, 4'h0, 32'h0, hs);
    wait_rsp(rc);
    check("t6_act_cycle", first_kind(K_ACT, hs, rc), hs + 1);
    check("t6_act_addr", a_at[hs + 1], 11'h300);
    check("t6_no_pre", count_kind(K_PRE, hs, rc), 0);
    check("t6_rdata", rsp_rdata, 32'h0BAD_F00D);
    release_rsp();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
